// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_arb data-memory arbiter: FSM states,
// access-size encodings and default bus widths.
package dmem_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 64;

    localparam logic [1:0] WORD_B = 2'b00;
    localparam logic [1:0] WORD_H = 2'b01;
    localparam logic [1:0] WORD_W = 2'b10;
    localparam logic [1:0] WORD_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_arb_rr.sv
// Combinational 2-way round-robin picker. lock_owner is one-hot (00 = no lock)
// and takes precedence over the pointer when its port is requesting.
module dmem_arb_rr (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic [1:0] lock_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if ((req & lock_owner) != 2'b00) begin
            grant = req & lock_owner;
        end else if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/dmem_arb.sv
// Two-port data-memory arbiter: IDLE -> ISSUE -> RESP, one access per 3 cycles.
// Optional grant locking is enabled with the macro DMEM_ARB_LOCK_EN.
module dmem_arb
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    word0,
    input  logic [1:0]    word1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_word,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_datar
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ptr;
    logic          r_owner;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_word;
    logic          r_rw;
    logic [DW-1:0] r_rdata;

    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic [1:0]    w_lock_owner;
    logic          w_start;
    logic          w_win;
    logic          w_win_lock;

    assign w_req   = {req1, req0};
    assign w_start = (r_state == IDLE) && (w_req != 2'b00);
    assign w_win   = w_grant[1];

    dmem_arb_rr u_rr (
        .req        (w_req),
        .ptr        (r_ptr),
        .lock_owner (w_lock_owner),
        .grant      (w_grant)
    );

`ifdef DMEM_ARB_LOCK_EN
    logic r_lock_vld;
    logic r_lock_own;

    assign w_win_lock   = w_win ? lock1 : lock0;
    assign w_lock_owner = r_lock_vld ? {r_lock_own, ~r_lock_own} : 2'b00;

    // Lock follows the lock bit of each new grant; an idle IDLE cycle drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld <= 1'b0;
            r_lock_own <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                r_lock_vld <= w_win_lock;
                r_lock_own <= w_win;
            end else begin
                r_lock_vld <= 1'b0;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = lock0 ^ lock1;
    assign w_win_lock    = 1'b0;
    assign w_lock_owner  = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req != 2'b00) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Winner fields are captured only at grant, so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= WORD_B;
            r_rw    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_owner <= w_win;
                r_addr  <= w_win ? addr1  : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
                r_word  <= w_win ? word1  : word0;
                r_rw    <= w_win ? rw1    : rw0;
                if (!w_win_lock) begin
                    r_ptr <= ~w_win;
                end
            end
            if (r_state == ISSUE) begin
                r_rdata <= mem_datar;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_word  = r_word;
    assign mem_rw    = (r_state == ISSUE) && r_rw;
    assign ack0      = (r_state == RESP) && !r_owner;
    assign ack1      = (r_state == RESP) && r_owner;
    assign rdata     = r_rdata;

endmodule
